// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // addi x0, x0, 0 -- presented on instrF whenever no real instruction is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch result: the instruction word and the PC it was fetched from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Head entry is visible combinationally on dout.
// Flush has priority over push/pop; push and pop in the same cycle keep count unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next-state for pointers, occupancy and storage; DEPTH is a power of 2 so pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            assert (!(push && full && !pop) || flush);
        end
    end

    // Storage needs no reset: contents are only read when count says they are valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// pairs responses with their PCs and presents one {instr, pc} per cycle to IF/ID.
//
// Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
// imem_req_valid never depends on imem_req_ready. Responses (imem_rsp_valid) arrive
// in request order and are never back-pressured. The IF/ID side consumes the head
// on a cycle where validF && !stallF.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        validF,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F
);

    localparam int OUT_W  = $clog2(MAX_OUT+1);
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_q, drop_d;

    logic             req_fire;
    logic             rsp_take;

    fetch_entry_t     ibuf_din, ibuf_head;
    logic             ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
    logic [CNT_W-1:0] ibuf_count;

    logic [31:0]      pcq_head;
    logic             pcq_push, pcq_pop, pcq_full, pcq_empty;
    logic [OUT_W-1:0] pcq_count;

    // Issue only when every outstanding response is guaranteed a buffer slot
    assign imem_req_valid = !reset && !pcsrcE
                          && (int'(outstanding_q) + int'(ibuf_count) < DEPTH)
                          && (int'(outstanding_q) < MAX_OUT);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when it belongs to the current path and no redirect is flushing
    assign rsp_take  = imem_rsp_valid && (drop_q == '0) && !pcsrcE;

    assign pcq_push  = req_fire;
    assign pcq_pop   = rsp_take;
    assign ibuf_push = rsp_take;
    assign ibuf_pop  = !ibuf_empty && !stallF && !pcsrcE;
    assign ibuf_din  = '{instr: imem_rsp_data, pc: pcq_head};

    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pcq_push),
        .pop   (pcq_pop),
        .flush (pcsrcE),
        .din   (fetch_pc_q),
        .dout  (pcq_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (ibuf_push),
        .pop   (ibuf_pop),
        .flush (pcsrcE),
        .din   (ibuf_din),
        .dout  (ibuf_head),
        .full  (ibuf_full),
        .empty (ibuf_empty),
        .count (ibuf_count)
    );

    // Next fetch PC and request bookkeeping; a redirect turns every in-flight request into a drop
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (pcsrcE) begin
            fetch_pc_d    = pctargetE & ~32'd3;
            outstanding_d = outstanding_q - OUT_W'(imem_rsp_valid);
            drop_d        = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
        end
    end

    // Fetch PC and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Invariants tying the counters to the two FIFOs
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (int'(pcq_count) + int'(drop_q) == int'(outstanding_q));
            assert (!(rsp_take && pcq_empty));
            assert (!(pcq_push && pcq_full && !pcq_pop));
            assert (!(ibuf_push && ibuf_full && !ibuf_pop));
        end
    end

    // Present the buffer head; with nothing held show a NOP at the next fetch PC
    always_comb begin
        validF   = !ibuf_empty;
        instrF   = validF ? ibuf_head.instr : NOP_INSTR;
        pcF      = validF ? ibuf_head.pc : fetch_pc_q;
        pcplus4F = pcF + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory model.
// Memory word at address a is a ^ 32'hA000_0000; responses come one cycle after acceptance
// unless mem_hold parks them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallF = 1'b0;
    logic        pcsrcE = 1'b0;
    logic [31:0] pctargetE = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;

    int          checks = 0;
    int          failures = 0;
    logic        mem_hold = 1'b0;
    logic [31:0] mq[$];

    // clock / reset
    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stallF         (stallF),
        .pcsrcE         (pcsrcE),
        .pctargetE      (pctargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .validF         (validF),
        .instrF         (instrF),
        .pcF            (pcF),
        .pcplus4F       (pcplus4F)
    );

    // memory model: capture accepted request at the edge, answer in order during the next cycle
    always @(posedge clk) begin : mem_model
        logic        fire_s;
        logic        rst_s;
        logic [31:0] addr_s;
        fire_s = imem_req_valid && imem_req_ready;
        rst_s  = reset;
        addr_s = imem_addr;
        #1;
        if (rst_s) mq.delete();
        else if (fire_s) mq.push_back(addr_s);
        if (!rst_s && !mem_hold && mq.size() > 0) begin
            imem_rsp_data  = mq.pop_front() ^ 32'hA000_0000;
            imem_rsp_valid = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // check the IF/ID-facing outputs; exp_pc only matters when an instruction is expected
    task automatic chk_f(input string tag, input logic exp_v, input logic [31:0] exp_pc);
        chk({tag, "_validF"}, 32'(validF), 32'(exp_v));
        if (exp_v) begin
            chk({tag, "_pcF"}, pcF, exp_pc);
            chk({tag, "_instrF"}, instrF, exp_pc ^ 32'hA000_0000);
            chk({tag, "_pcplus4F"}, pcplus4F, exp_pc + 32'd4);
        end else begin
            chk({tag, "_instrF_nop"}, instrF, 32'h0000_0013);
        end
    endtask

    // driver: change inputs mid-cycle, let combinational outputs settle before checks
    task automatic drive(input logic stall, input logic src, input logic [31:0] tgt,
                         input logic rdy, input logic hold);
        @(negedge clk);
        stallF = stall; pcsrcE = src; pctargetE = tgt; imem_req_ready = rdy; mem_hold = hold;
        #1;
    endtask

    // reset for 3 sampled edges; returns 1 ns into the first cycle after release
    task automatic do_reset(input logic rdy, input logic hold);
        @(negedge clk);
        reset = 1'b1; stallF = 1'b0; pcsrcE = 1'b0; pctargetE = 32'h0;
        imem_req_ready = rdy; mem_hold = hold;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // 1: reset state and first request
        do_reset(1'b1, 1'b0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_pcplus4F", pcplus4F, 32'h4);
        chk_f("rst", 1'b0, 32'h0);

        // 2: straight line, memory always ready
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sl_c2", 1'b0, 32'h0);
        chk("sl_c2_addr", imem_addr, 32'h4);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sl_c3", 1'b1, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sl_c4", 1'b1, 32'h4);

        // 3: stall with pcF=0x8 for 4 cycles; issue throttles once buffer+outstanding fills
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c5", 1'b1, 32'h8);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c6", 1'b1, 32'h8);
        chk("st_c6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("st_c6_addr", imem_addr, 32'h14);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c7", 1'b1, 32'h8);
        chk("st_c7_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c8", 1'b1, 32'h8);
        chk("st_c8_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c9", 1'b1, 32'h8);
        chk("st_c9_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c10", 1'b1, 32'hC);
        chk("st_c10_addr", imem_addr, 32'h18);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("st_c11", 1'b1, 32'h10);

        // stall and redirect together: redirect flushes the held entries
        drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        chk_f("sr_c12", 1'b1, 32'h14);
        chk("sr_c12_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sr_c13", 1'b0, 32'h0);
        chk("sr_c13_addr", imem_addr, 32'h40);
        chk("sr_c13_req_valid", 32'(imem_req_valid), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sr_c14", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("sr_c15", 1'b1, 32'h40);

        // 4: redirect to 0x103 with two requests outstanding
        do_reset(1'b1, 1'b1);
        chk("rd_c1_addr", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rd_c2_addr", imem_addr, 32'h4);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rd_c3_req_valid_maxout", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h103, 1'b1, 1'b0);
        chk("rd_c4_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rd_c5", 1'b0, 32'h0);
        chk("rd_c5_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rd_c6", 1'b0, 32'h0);
        chk("rd_c6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_c6_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rd_c7", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rd_c8", 1'b1, 32'h100);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rd_c9", 1'b1, 32'h104);

        // 5: redirect in the same cycle a response arrives
        do_reset(1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        chk("rr_c4_req_valid", 32'(imem_req_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rr_c5", 1'b0, 32'h0);
        chk("rr_c5_addr", imem_addr, 32'h300);
        chk("rr_c5_req_valid", 32'(imem_req_valid), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rr_c6", 1'b0, 32'h0);
        chk("rr_c6_addr", imem_addr, 32'h304);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("rr_c7", 1'b1, 32'h300);

        // 6: request held by memory at 0xFFFF_FFFC, then PC wraps to 0
        do_reset(1'b0, 1'b0);
        pcsrcE = 1'b1; pctargetE = 32'hFFFF_FFFE;
        #1;
        chk("wr_c1_req_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("wr_hold_req_valid", 32'(imem_req_valid), 32'd1);
            chk("wr_hold_addr", imem_addr, 32'hFFFF_FFFC);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wr_c7_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wr_c8_addr", imem_addr, 32'h0);
        chk_f("wr_c8", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("wr_c9", 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_f("wr_c10", 1'b1, 32'h0);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
